// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch stage: NOP default, width helpers and
// the output-register source selector.
package fetch_pkg;

    localparam int unsigned NOP_DEFAULT = 0;

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Depth is a power of two >= 2, so pointers wrap naturally at this width.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        SRC_HOLD,
        SRC_HEAD,
        SRC_BYPASS,
        SRC_NOP
    } out_src_e;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// Circular buffer for the prefetch queue: push/pop/clear with registered
// count and full flag.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PW = ptr_w(DEPTH),
    localparam int unsigned CW = count_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // When full, tail == head: the pop reads mem_q before the write lands.
            if (push) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue: output register to stage 1,
// empty-queue bypass path and PC/RA increment controls.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DATA_W    = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_DEFAULT)
) (
    input  logic                       ClockIn,
    input  logic                       ResetIn_n,
    input  logic                       BusRequest,
    input  logic [DATA_W-1:0]          MemData,
    input  logic                       FetchSuppress,
    input  logic                       Flush,
    input  logic                       PcraFlip,
    output logic [DATA_W-1:0]          PipeOut,
    output logic                       PipeValid,
    output logic                       IncPCRA0,
    output logic                       IncPCRA1,
    output logic [$clog2(DEPTH+1)-1:0] QueueCount,
    output logic                       QueueFull
);

    logic [DATA_W-1:0] head_data;
    logic              q_empty;
    logic              pop, accept, bypass;
    logic              fifo_push, fifo_pop;
    out_src_e          src;
    logic [DATA_W-1:0] pipe_out_q, pipe_out_d;
    logic              pipe_valid_q, pipe_valid_d;

    assign q_empty   = (QueueCount == '0);
    assign pop       = !FetchSuppress && !Flush;
    assign accept    = !BusRequest && !Flush && (!QueueFull || pop);
    assign bypass    = accept && pop && q_empty;
    assign fifo_push = accept && !bypass;
    assign fifo_pop  = pop && !q_empty;

    assign IncPCRA0 = accept && !PcraFlip;
    assign IncPCRA1 = accept && PcraFlip;

    fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (ClockIn),
        .rst_n (ResetIn_n),
        .clear (Flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (MemData),
        .rdata (head_data),
        .count (QueueCount),
        .full  (QueueFull)
    );

    always_comb begin
        if (Flush)         src = SRC_NOP;
        else if (!pop)     src = SRC_HOLD;
        else if (!q_empty) src = SRC_HEAD;
        else if (bypass)   src = SRC_BYPASS;
        else               src = SRC_NOP;
    end

    always_comb begin
        pipe_out_d   = pipe_out_q;
        pipe_valid_d = pipe_valid_q;
        case (src)
            SRC_HEAD: begin
                pipe_out_d   = head_data;
                pipe_valid_d = 1'b1;
            end
            SRC_BYPASS: begin
                pipe_out_d   = MemData;
                pipe_valid_d = 1'b1;
            end
            SRC_NOP: begin
                pipe_out_d   = NOP_VALUE;
                pipe_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            pipe_out_q   <= NOP_VALUE;
            pipe_valid_q <= 1'b0;
        end else begin
            pipe_out_q   <= pipe_out_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign PipeOut   = pipe_out_q;
    assign PipeValid = pipe_valid_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fetch_prefetch_queue;

    logic       ClockIn = 1'b0;
    logic       ResetIn_n;
    logic       BusRequest;
    logic [7:0] MemData;
    logic       FetchSuppress;
    logic       Flush;
    logic       PcraFlip;
    logic [7:0] PipeOut;
    logic       PipeValid;
    logic       IncPCRA0;
    logic       IncPCRA1;
    logic [2:0] QueueCount;
    logic       QueueFull;

    always #5 ClockIn = ~ClockIn;

    fetch_prefetch_queue #(
        .DATA_W    (8),
        .DEPTH     (4),
        .NOP_VALUE (8'h00)
    ) dut (
        .ClockIn       (ClockIn),
        .ResetIn_n     (ResetIn_n),
        .BusRequest    (BusRequest),
        .MemData       (MemData),
        .FetchSuppress (FetchSuppress),
        .Flush         (Flush),
        .PcraFlip      (PcraFlip),
        .PipeOut       (PipeOut),
        .PipeValid     (PipeValid),
        .IncPCRA0      (IncPCRA0),
        .IncPCRA1      (IncPCRA1),
        .QueueCount    (QueueCount),
        .QueueFull     (QueueFull)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of pending words plus the presented word.
    byte unsigned mq[$];
    logic [7:0]   m_out;
    logic         m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out   = 8'h00;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit p, acc;
        p   = !FetchSuppress && !Flush;
        acc = !BusRequest && !Flush && (mq.size() < 4 || p);
        chk({tag, "_out"},   PipeOut,    m_out);
        chk({tag, "_valid"}, PipeValid,  m_valid);
        chk({tag, "_count"}, QueueCount, mq.size());
        chk({tag, "_full"},  QueueFull,  mq.size() == 4);
        chk({tag, "_inc0"},  IncPCRA0,   acc && !PcraFlip);
        chk({tag, "_inc1"},  IncPCRA1,   acc && PcraFlip);
    endtask

    task automatic model_step(input bit bus, input byte unsigned md, input bit fs, input bit fl);
        bit p, acc, byp;
        p   = !fs && !fl;
        acc = !bus && !fl && (mq.size() < 4 || p);
        byp = acc && p && mq.size() == 0;
        if (fl) begin
            mq.delete();
            m_out   = 8'h00;
            m_valid = 1'b0;
        end else begin
            if (p) begin
                if (mq.size() > 0) begin
                    m_out   = mq.pop_front();
                    m_valid = 1'b1;
                end else if (byp) begin
                    m_out   = md;
                    m_valid = 1'b1;
                end else begin
                    m_out   = 8'h00;
                    m_valid = 1'b0;
                end
            end
            if (acc && !byp) mq.push_back(md);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance model with the edge.
    task automatic cyc(input string tag, input bit bus, input byte unsigned md,
                       input bit fs, input bit fl, input bit flip);
        BusRequest    = bus;
        MemData       = md;
        FetchSuppress = fs;
        Flush         = fl;
        PcraFlip      = flip;
        @(negedge ClockIn);
        check_all(tag);
        @(posedge ClockIn);
        model_step(bus, md, fs, fl);
        #1;
    endtask

    initial begin
        ResetIn_n     = 1'b0;
        BusRequest    = 1'b0;
        MemData       = 8'h00;
        FetchSuppress = 1'b0;
        Flush         = 1'b0;
        PcraFlip      = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge ClockIn);
        #1;
        ResetIn_n = 1'b1;

        // Free-run, bypass path
        cyc("run", 0, 8'h11, 0, 0, 0);
        cyc("run", 0, 8'h22, 0, 0, 0);
        cyc("run", 0, 8'h33, 0, 0, 0);
        chk("run_last_out", PipeOut, 8'h33);

        // Stall fills the queue, excess not accepted
        for (int i = 0; i < 6; i++) cyc("stall", 0, 8'hA0 + 8'(i), 1, 0, 0);
        chk("stall_full", QueueFull, 1'b1);
        chk("stall_hold", PipeOut, 8'h33);

        // Full queue with push and pop each cycle; pointers wrap
        for (int i = 0; i < 6; i++) cyc("wrap", 0, 8'hB0 + 8'(i), 0, 0, 0);
        chk("wrap_count", QueueCount, 3'd4);
        chk("wrap_out", PipeOut, 8'hB1);

        // Drain under bus loss
        for (int i = 0; i < 6; i++) cyc("drain", 1, 8'hEE, 0, 0, 0);
        chk("drain_nop", PipeValid, 1'b0);

        // Two entries then bus loss
        cyc("two", 0, 8'hC0, 1, 0, 0);
        cyc("two", 0, 8'hC1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc("bus", 1, 8'h5A, 0, 0, 0);

        // Three entries then flush
        cyc("three", 0, 8'hD0, 1, 0, 0);
        cyc("three", 0, 8'hD1, 1, 0, 0);
        cyc("three", 0, 8'hD2, 1, 0, 0);
        cyc("flush", 0, 8'hD3, 0, 1, 0);
        chk("flush_count", QueueCount, 3'd0);
        chk("flush_valid", PipeValid, 1'b0);
        chk("flush_out", PipeOut, 8'h00);
        cyc("resume", 0, 8'hE0, 0, 0, 0);
        cyc("resume", 0, 8'hE1, 0, 0, 0);
        chk("resume_out", PipeOut, 8'hE1);

        // Asynchronous reset while draining
        cyc("pre_rst", 0, 8'h71, 1, 0, 0);
        cyc("pre_rst", 0, 8'h72, 1, 0, 0);
        cyc("pre_rst", 1, 8'h73, 0, 0, 0);
        #2;
        ResetIn_n = 1'b0;
        #1;
        chk("arst_count", QueueCount, 3'd0);
        chk("arst_full", QueueFull, 1'b0);
        chk("arst_valid", PipeValid, 1'b0);
        chk("arst_out", PipeOut, 8'h00);
        model_reset();
        @(posedge ClockIn);
        #1;
        ResetIn_n = 1'b1;
        cyc("flip", 0, 8'h81, 0, 0, 1);
        cyc("flip", 0, 8'h82, 0, 0, 1);
        chk("flip_out", PipeOut, 8'h82);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(99, 0) < 25,
                8'($urandom),
                $urandom_range(99, 0) < 35,
                $urandom_range(99, 0) < 5,
                1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
